// File: rtl/pwm_multichannel_gen_if.sv
// Control/status bundle of the multi-channel PWM generator.
interface pwm_multichannel_gen_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PERIOD   = 10
);
    localparam int unsigned CW  = $clog2(PERIOD + 1);
    localparam int unsigned CSW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CSW-1:0]      ch_sel;
    logic                increase_duty;
    logic                decrease_duty;
    logic                center_mode;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_start;
    logic [CW-1:0]       duty_rd;

    modport master (
        output ch_sel, increase_duty, decrease_duty, center_mode,
        input  pwm_out, period_start, duty_rd
    );

    modport slave (
        input  ch_sel, increase_duty, decrease_duty, center_mode,
        output pwm_out, period_start, duty_rd
    );
endinterface

// File: rtl/pwm_multichannel_gen.sv
// Multi-channel PWM generator: shared period counter, per-channel
// double-buffered duty stepped by button edges, edge/center-aligned modes.
module pwm_multichannel_gen #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned PERIOD    = 10,
    parameter int unsigned STEP      = 1,
    parameter int unsigned DUTY_INIT = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    pwm_multichannel_gen_if.slave bus
);
    localparam int unsigned CW  = $clog2(PERIOD + 1);
    localparam int unsigned CWX = CW + 1;

    localparam logic [CW-1:0]  CNT_LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0]  DUTY_RST = CW'(DUTY_INIT);
    localparam logic [CWX-1:0] DUTY_MAX = CWX'(PERIOD);
    localparam logic [CWX-1:0] STEP_W   = CWX'(STEP);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    logic [CW-1:0] cnt;
    dir_e          dir;
    logic          mode_act;
    logic          inc_prev;
    logic          dec_prev;
    logic          restart;
    logic [CW-1:0] duty_pend     [CHANNELS];
    logic [CW-1:0] duty_act      [CHANNELS];
    logic [CW-1:0] duty_pend_nxt [CHANNELS];
    logic          inc_ev_c;
    logic          dec_ev_c;
    logic          boundary_c;

    // Saturating duty step computed one bit wider so it never wraps.
    function automatic logic [CW-1:0] step_duty(input logic [CW-1:0] d, input logic up);
        logic [CWX-1:0] wide;
        wide = CWX'(d);
        if (up) begin
            wide = wide + STEP_W;
            if (wide > DUTY_MAX) begin
                wide = DUTY_MAX;
            end
        end else begin
            wide = (wide > STEP_W) ? (wide - STEP_W) : '0;
        end
        return wide[CW-1:0];
    endfunction

    assign inc_ev_c   = bus.increase_duty & ~inc_prev;
    assign dec_ev_c   = bus.decrease_duty & ~dec_prev;
    assign boundary_c = mode_act ? (dir == DIR_DOWN && cnt == '0) : (cnt == CNT_LAST);

    // Next pending duty: only the addressed channel moves, opposing events cancel.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            duty_pend_nxt[i] = duty_pend[i];
            if (int'(bus.ch_sel) == i && (inc_ev_c ^ dec_ev_c)) begin
                duty_pend_nxt[i] = step_duty(duty_pend[i], inc_ev_c);
            end
        end
    end

    // Pending duty readback; out-of-range selects read as zero.
    always_comb begin
        bus.duty_rd = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(bus.ch_sel) == i) begin
                bus.duty_rd = duty_pend[i];
            end
        end
    end

    // Counter, duty buffers, boundary hand-over and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt              <= '0;
            dir              <= DIR_UP;
            mode_act         <= 1'b0;
            inc_prev         <= 1'b0;
            dec_prev         <= 1'b0;
            restart          <= 1'b1;
            bus.period_start <= 1'b0;
            bus.pwm_out      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_pend[i] <= DUTY_RST;
                duty_act[i]  <= DUTY_RST;
            end
        end else begin
            inc_prev         <= bus.increase_duty;
            dec_prev         <= bus.decrease_duty;
            restart          <= boundary_c;
            bus.period_start <= restart;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_pend[i]   <= duty_pend_nxt[i];
                bus.pwm_out[i] <= (cnt < duty_act[i]);
                if (boundary_c) begin
                    duty_act[i] <= duty_pend_nxt[i];
                end
            end
            if (boundary_c) begin
                cnt      <= '0;
                dir      <= DIR_UP;
                mode_act <= bus.center_mode;
            end else if (!mode_act) begin
                cnt <= cnt + CW'(1);
            end else if (dir == DIR_UP) begin
                // Top value is held for a second cycle while turning around.
                if (cnt == CNT_LAST) begin
                    dir <= DIR_DOWN;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule
